// File: rtl/ex_mem_skid.sv
// rtl/ex_mem_skid.sv - EX/MEM pipeline register with a two-entry skid buffer and registered InReady
// Optional EX_MEM_FWD_EN adds the FwdValid/FwdRd/FwdData operand-forwarding outputs.
module ex_mem_skid #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      InValid,
   output logic                      InReady,
   input  logic [DATA_WIDTH-1:0]     InALUResult,
   input  logic [DATA_WIDTH-1:0]     InStoreData,
   input  logic [REG_ADDR_WIDTH-1:0] InRd,
   input  logic                      InRegWrite,
   input  logic                      InMemRead,
   input  logic                      InMemWrite,
   input  logic                      Flush,
   output logic                      OutValid,
   input  logic                      OutReady,
   output logic [DATA_WIDTH-1:0]     OutALUResult,
   output logic [DATA_WIDTH-1:0]     OutStoreData,
   output logic [REG_ADDR_WIDTH-1:0] OutRd,
   output logic                      OutRegWrite,
   output logic                      OutMemRead,
   output logic                      OutMemWrite
`ifdef EX_MEM_FWD_EN
   ,
   output logic                      FwdValid,
   output logic [REG_ADDR_WIDTH-1:0] FwdRd,
   output logic [DATA_WIDTH-1:0]     FwdData
`endif
);

   localparam int ENTRY_W = 2 * DATA_WIDTH + REG_ADDR_WIDTH + 3;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [ENTRY_W-1:0]   main_q, main_d;
   logic [ENTRY_W-1:0]   skid_q, skid_d;
   logic                 in_ready_q, in_ready_d;
   logic [ENTRY_W-1:0]   in_entry;
   logic                 accept, pop;
   logic                 main_rw, main_mr, main_mw;

   // RegWrite is dropped at capture time for x0 so nothing downstream can write it.
   assign in_entry = {InALUResult, InStoreData, InRd,
                      InRegWrite && (InRd != '0), InMemRead, InMemWrite};

   assign {OutALUResult, OutStoreData, OutRd, main_rw, main_mr, main_mw} = main_q;

   assign OutValid    = (state_q != S_EMPTY);
   assign OutRegWrite = OutValid && main_rw;
   assign OutMemRead  = OutValid && main_mr;
   assign OutMemWrite = OutValid && main_mw;
   assign InReady     = in_ready_q;

   assign accept = InValid && in_ready_q;
   assign pop    = OutValid && OutReady;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (Flush) begin
         state_d = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (accept) begin
                  state_d = S_ONE;
                  main_d  = in_entry;
               end
            end
            S_ONE: begin
               if (accept && pop) begin
                  main_d = in_entry;
               end else if (accept) begin
                  state_d = S_FULL;
                  skid_d  = in_entry;
               end else if (pop) begin
                  state_d = S_EMPTY;
               end
            end
            S_FULL: begin
               if (pop) begin
                  state_d = S_ONE;
                  main_d  = skid_q;
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end
      // Ready is a pure function of the next state, so OutReady never reaches InReady combinationally.
      in_ready_d = (state_d != S_FULL);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

`ifdef EX_MEM_FWD_EN
   assign FwdValid = OutValid && OutRegWrite && !OutMemRead;
   assign FwdRd    = OutRd;
   assign FwdData  = OutALUResult;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// tb/tb_ex_mem_skid.sv - Self-checking bench for ex_mem_skid against a queue-based reference model
// Build with EX_MEM_FWD_EN defined to also cover the forwarding outputs.
module tb_ex_mem_skid;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] sd;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset, InValid, InReady, Flush, OutValid, OutReady;
   logic [31:0] InALUResult, InStoreData, OutALUResult, OutStoreData;
   logic [4:0]  InRd, OutRd;
   logic        InRegWrite, InMemRead, InMemWrite;
   logic        OutRegWrite, OutMemRead, OutMemWrite;
`ifdef EX_MEM_FWD_EN
   logic        FwdValid;
   logic [4:0]  FwdRd;
   logic [31:0] FwdData;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   ent_t mq[$];
   logic m_rdy;
   ent_t m_last;

   always #5 clk = ~clk;

   ex_mem_skid #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
      .clk(clk), .reset(reset),
      .InValid(InValid), .InReady(InReady),
      .InALUResult(InALUResult), .InStoreData(InStoreData), .InRd(InRd),
      .InRegWrite(InRegWrite), .InMemRead(InMemRead), .InMemWrite(InMemWrite),
      .Flush(Flush), .OutValid(OutValid), .OutReady(OutReady),
      .OutALUResult(OutALUResult), .OutStoreData(OutStoreData), .OutRd(OutRd),
      .OutRegWrite(OutRegWrite), .OutMemRead(OutMemRead), .OutMemWrite(OutMemWrite)
`ifdef EX_MEM_FWD_EN
      , .FwdValid(FwdValid), .FwdRd(FwdRd), .FwdData(FwdData)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic ent_t mk(input logic [31:0] alu, input logic [4:0] rd,
                               input logic rw, input logic mr, input logic mw);
      ent_t e;
      e.alu = alu; e.sd = ~alu; e.rd = rd; e.rw = rw; e.mr = mr; e.mw = mw;
      return e;
   endfunction

   // Compare every DUT output with what the model queue says should be visible.
   task automatic check_all();
      logic v;
      v = (mq.size() > 0);
      chk("InReady", 64'(InReady), 64'(m_rdy));
      chk("OutValid", 64'(OutValid), 64'(v));
      chk("OutALUResult", 64'(OutALUResult), 64'(m_last.alu));
      chk("OutStoreData", 64'(OutStoreData), 64'(m_last.sd));
      chk("OutRd", 64'(OutRd), 64'(m_last.rd));
      chk("OutCtrl", 64'({OutRegWrite, OutMemRead, OutMemWrite}),
          64'({v && m_last.rw, v && m_last.mr, v && m_last.mw}));
`ifdef EX_MEM_FWD_EN
      chk("FwdValid", 64'(FwdValid), 64'(v && m_last.rw && !m_last.mr));
      chk("FwdRd", 64'(FwdRd), 64'(m_last.rd));
      chk("FwdData", 64'(FwdData), 64'(m_last.alu));
`endif
   endtask

   task automatic step(input logic rst, input logic fl, input logic iv, input logic ordy, input ent_t e);
      logic acc, pp;
      ent_t e2;
      reset = rst; Flush = fl; InValid = iv; OutReady = ordy;
      InALUResult = e.alu; InStoreData = e.sd; InRd = e.rd;
      InRegWrite = e.rw; InMemRead = e.mr; InMemWrite = e.mw;
      acc = iv && m_rdy;
      pp  = (mq.size() > 0) && ordy;
      @(posedge clk);
      #1;
      if (rst) begin
         mq.delete();
         m_rdy  = 1'b0;
         m_last = '0;
      end else if (fl) begin
         mq.delete();
         m_rdy = 1'b1;
      end else begin
         if (pp) void'(mq.pop_front());
         if (acc) begin
            e2 = e;
            e2.rw = e.rw && (e.rd != 5'd0);
            mq.push_back(e2);
         end
         m_rdy = (mq.size() < 2);
      end
      if (mq.size() > 0) m_last = mq[0];
      check_all();
   endtask

   initial begin
      ent_t z, r;
      z = '0;
      m_rdy = 1'b0;
      m_last = '0;

      step(1, 0, 0, 0, z);
      step(1, 0, 1, 1, mk(32'h55, 5'd3, 1, 0, 0));
      chk("rst_outvalid", 64'(OutValid), 64'd0);
      chk("rst_inready", 64'(InReady), 64'd0);
      chk("rst_alu", 64'(OutALUResult), 64'd0);
      step(0, 0, 0, 0, z);
      chk("post_rst_inready", 64'(InReady), 64'd1);

      // single transfer
      step(0, 0, 1, 1, mk(32'h10, 5'd5, 1, 0, 0));
      chk("single_valid", 64'(OutValid), 64'd1);
      chk("single_alu", 64'(OutALUResult), 64'h10);
      chk("single_rd", 64'(OutRd), 64'd5);
      chk("single_rw", 64'(OutRegWrite), 64'd1);
      step(0, 0, 0, 1, z);
      chk("single_drained", 64'(OutValid), 64'd0);

      // backpressure
      step(0, 0, 1, 0, mk(32'hA, 5'd1, 1, 0, 0));
      step(0, 0, 1, 0, mk(32'hB, 5'd2, 1, 0, 0));
      chk("bp_full_inready", 64'(InReady), 64'd0);
      chk("bp_hold_a", 64'(OutALUResult), 64'hA);
      step(0, 0, 1, 0, mk(32'hC, 5'd2, 1, 0, 0));
      chk("bp_still_a", 64'(OutALUResult), 64'hA);
      step(0, 0, 0, 1, z);
      chk("bp_then_b", 64'(OutALUResult), 64'hB);
      step(0, 0, 0, 1, z);
      chk("bp_empty", 64'(OutValid), 64'd0);

      // streaming
      for (int k = 1; k <= 8; k++) begin
         step(0, 0, 1, 1, mk(32'(k), 5'd7, 1, 0, 0));
         chk("stream_alu", 64'(OutALUResult), 64'(k));
         chk("stream_inready", 64'(InReady), 64'd1);
      end
      step(0, 0, 0, 1, z);

      // flush while full with a same-cycle offer
      step(0, 0, 1, 0, mk(32'h111, 5'd4, 1, 1, 0));
      step(0, 0, 1, 0, mk(32'h222, 5'd4, 1, 0, 1));
      step(0, 1, 1, 1, mk(32'hDEAD, 5'd6, 1, 0, 0));
      chk("flush_valid", 64'(OutValid), 64'd0);
      chk("flush_inready", 64'(InReady), 64'd1);
      step(0, 0, 0, 1, z);
      chk("flush_gone", 64'(OutValid), 64'd0);

      // x0 destination
      step(0, 0, 1, 0, mk(32'h77, 5'd0, 1, 0, 0));
      chk("x0_rw", 64'(OutRegWrite), 64'd0);
      step(0, 0, 0, 1, z);

      // reset with two entries in flight
      step(0, 0, 1, 0, mk(32'h333, 5'd8, 1, 0, 0));
      step(0, 0, 1, 0, mk(32'h444, 5'd9, 0, 1, 0));
      step(1, 1, 1, 1, mk(32'h555, 5'd9, 1, 0, 0));
      chk("midrst_valid", 64'(OutValid), 64'd0);
      chk("midrst_alu", 64'(OutALUResult), 64'd0);
      chk("midrst_rd", 64'(OutRd), 64'd0);
      step(0, 0, 0, 0, z);
      chk("midrst_inready", 64'(InReady), 64'd1);

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         r = mk($urandom, 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom));
         r.sd = $urandom;
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
              1'($urandom), ($urandom_range(0, 2) != 0), r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
